ssd_scan_ctrl: RTL
==================

# ssd_scan_ctrl

Parametrised multi-digit seven-segment scan controller: time-multiplexes N_DIGITS hex digits with decimal points onto shared segment lines. It adds per-digit blanking, anti-ghosting dead time, PWM brightness and tear-free frame-synchronous updates. It sits below the SSD peripheral wrapper, fed from its software registers, and drives the board anode/segment pins directly.

## Interface
Parameters:
- N_DIGITS, 4, number of digits / anode lines (1..16)
- SCAN_DIV, 100000, clock cycles per digit slot (≥ DEAD_CYC + 2^BRIGHT_W)
- DEAD_CYC, 8, cycles at slot start with all anodes off (≥ 1)
- BRIGHT_W, 4, brightness code width
- ANODE_ACT_LOW, 1, anode outputs active-low when 1
- SEG_ACT_LOW, 1, segment outputs active-low when 1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  one-cycle strobe: capture data_in/dp_in/blank_in into shadow
- data_in  in  4*N_DIGITS  hex nibble per digit, digit i = bits [4i+3:4i]
- dp_in  in  N_DIGITS  decimal point per digit
- blank_in  in  N_DIGITS  1 = digit i never lit
- bright  in  BRIGHT_W  brightness code, sampled at each slot start
- pending  out  1  shadow holds values not yet displayed
- frame_done  out  1  one-cycle pulse at each frame commit point
- anode  out  N_DIGITS  digit select (polarity per ANODE_ACT_LOW)
- seg  out  8  seg[0]=a … seg[6]=g, seg[7]=dp (polarity per SEG_ACT_LOW)

## Operation
- Slot counter c: 0..SCAN_DIV-1, wraps; digit index d increments on wrap, 0..N_DIGITS-1, wraps to 0 (frame boundary).
- Shadow regs load on load=1; pending set. Repeated loads while pending: latest wins.
- Commit: at c=0,d=0, if pending, shadow → display regs, pending cleared, frame_done pulses. frame_done pulses at every frame boundary regardless of pending.
- load coinciding with commit cycle: old shadow commits; new value captured, pending stays 1, applied next frame.
- seg = hex decode of display nibble d plus dp bit; standard hex glyphs (0=0x3F, 1=0x06, A=0x77, F=0x71, active-high form).
- Anode d active iff blank[d]=0 and DEAD_CYC ≤ c < DEAD_CYC + (((b+1)*(SCAN_DIV-DEAD_CYC)) >> BRIGHT_W), b = bright latched at c=0. b=all-ones → lit to slot end.
- At most one anode active at any cycle.

## Timing
- anode, seg, frame_done, pending registered: reflect counter state of previous cycle (1-cycle latency).
- seg changes only in the cycle after c=0, always inside dead time (anodes off).
- pending rises the cycle after load; falls the cycle after commit.
- Reset (async assert, any time incl. mid-frame): c=0, d=0, shadow/display regs 0, pending=0, frame_done=0, anode all inactive, seg all inactive (active-low: all ones). First slot after release is digit 0; display regs 0 (glyph "0" on unblanked digits).

## Configuration
- SSD_SCAN_PWM_EN defined: brightness window as above.
- Not defined: bright ignored, no latch logic; anode active for DEAD_CYC ≤ c < SCAN_DIV.

## Structure
- Shared package ssd_scan_pkg: 16-entry hex-to-segment glyph constants, segment bit index constants, dp bit position.
- One sub-module: ssd_hex_decode (nibble + dp → 8-bit active-high pattern); polarity applied in ssd_scan_ctrl.

## Test plan
Config N_DIGITS=4, SCAN_DIV=64, DEAD_CYC=2, BRIGHT_W=4, both active-low, PWM enabled.
- Reset release, no load -> anode=4'hF through cycle 2; digit 0 lit cycles 3..64 with seg=8'hC0; digits rotate 0,1,2,3,0 every 64 cycles.
- load data_in=16'h10AF, dp_in=4'b0001 mid-frame -> pending=1; display unchanged until frame boundary; then digit0 seg=8'h0E (F+dp), digit1 8'h88, digit2 8'hC0, digit3 8'hF9; frame_done pulse, pending=0.
- bright=0 -> each digit lit exactly 3 cycles per slot ((1*62)>>4); bright=7 -> 31 cycles; bright=15 -> 62 cycles.
- blank_in=4'b0101 committed -> anode[0], anode[2] never active; anode[1], anode[3] unaffected.
- load on commit cycle and again 10 cycles prior -> earlier value shown this frame, later value next frame, pending=1 between.
- Assert rst mid-slot of digit 2 -> anode=4'hF, seg=8'hFF next edge, pending=0; after release scan restarts at digit 0 showing "0".

Source files
------------

// File: rtl/ssd_scan_pkg.sv
// Shared constants for the seven-segment scan controller.
// Holds the hex glyph table (active-high, seg[0]=a .. seg[6]=g) and segment bit positions.
package ssd_scan_pkg;

    localparam int SEG_W  = 8;
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/ssd_hex_decode.sv
// Hex nibble plus decimal point to an active-high 8-bit segment pattern.
module ssd_hex_decode
    import ssd_scan_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             dp,
    output logic [SEG_W-1:0] pattern
);

    always_comb begin
        pattern               = '0;
        pattern[SEG_G:SEG_A]  = HEX_GLYPH[nibble];
        pattern[SEG_DP]       = dp;
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multi-digit seven-segment scan controller with blanking, dead time and frame-synchronous updates.
// Define SSD_SCAN_PWM_EN to enable the brightness window driven by the bright input.
module ssd_scan_ctrl
    import ssd_scan_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int SCAN_DIV      = 100000,
    parameter int DEAD_CYC      = 8,
    parameter int BRIGHT_W      = 4,
    parameter int ANODE_ACT_LOW = 1,
    parameter int SEG_ACT_LOW   = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic                  pending,
    output logic                  frame_done,
    output logic [N_DIGITS-1:0]   anode,
    output logic [SEG_W-1:0]      seg
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]    DIG_LAST  = DIG_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ANODE_OFF = (ANODE_ACT_LOW != 0) ? '1 : '0;
    localparam logic [SEG_W-1:0]    SEG_OFF   = (SEG_ACT_LOW != 0) ? '1 : '0;
    localparam logic [31:0]         DEAD_END  = 32'(DEAD_CYC);

    logic [CNT_W-1:0]      cnt;
    logic [DIG_W-1:0]      dig;
    logic [4*N_DIGITS-1:0] shadow_data, disp_data, data_next;
    logic [N_DIGITS-1:0]   shadow_dp, disp_dp, dp_next;
    logic [N_DIGITS-1:0]   shadow_blank, disp_blank;
    logic                  slot_start, frame_start, commit;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic [SEG_W-1:0]      glyph;
    logic [31:0]           cnt_ext, lit_end;
    logic                  lit;
    logic [N_DIGITS-1:0]   sel;

    assign slot_start  = (cnt == '0);
    assign frame_start = slot_start && (dig == '0);
    assign commit      = frame_start && pending;

    // seg loads at slot start, so it must already see a frame being committed on that same edge
    assign data_next  = commit ? shadow_data : disp_data;
    assign dp_next    = commit ? shadow_dp   : disp_dp;
    assign cur_nibble = data_next[{dig, 2'b00} +: 4];
    assign cur_dp     = dp_next[dig];

    ssd_hex_decode u_hex_decode (
        .nibble  (cur_nibble),
        .dp      (cur_dp),
        .pattern (glyph)
    );

    assign cnt_ext = 32'(cnt);

`ifdef SSD_SCAN_PWM_EN
    localparam logic [31:0] SPAN = 32'(SCAN_DIV - DEAD_CYC);
    logic [BRIGHT_W-1:0] bright_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bright_q <= '0;
        end else if (slot_start) begin
            bright_q <= bright;
        end
    end

    assign lit_end = DEAD_END + (((32'(bright_q) + 32'd1) * SPAN) >> BRIGHT_W);
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign lit_end       = 32'(SCAN_DIV);
`endif

    always_comb begin
        sel = '0;
        lit = !disp_blank[dig] && (cnt_ext >= DEAD_END) && (cnt_ext < lit_end);
        if (lit) begin
            sel[dig] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            dig          <= '0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            disp_data    <= '0;
            disp_dp      <= '0;
            disp_blank   <= '0;
            pending      <= 1'b0;
            frame_done   <= 1'b0;
            anode        <= ANODE_OFF;
            seg          <= SEG_OFF;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                dig <= (dig == DIG_LAST) ? '0 : dig + DIG_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // a load on the commit edge is captured after the old shadow has moved across
            if (load) begin
                shadow_data  <= data_in;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_in;
            end
            if (commit) begin
                disp_data  <= shadow_data;
                disp_dp    <= shadow_dp;
                disp_blank <= shadow_blank;
            end
            pending    <= load | (pending & ~commit);
            frame_done <= frame_start;

            anode <= sel ^ ANODE_OFF;
            if (slot_start) begin
                seg <= glyph ^ SEG_OFF;
            end
        end
    end

endmodule
